// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 matrix keypad scanner.
// Strobes columns (active-low), samples the row lines through a 2-flop
// synchronizer, debounces press and release, and encodes each accepted key
// as col_idx*4 + row_idx. Events are queued in a small FIFO that is read
// through a valid/ready handshake.
// Optional feature: define KEYSCAN_AUTOREPEAT_EN to re-enqueue a held key
// every REPEAT_TICKS scan ticks.
module keypad_scan_ctrl #(
  parameter int unsigned CLK_DIV        = 50,
  parameter int unsigned DEBOUNCE_TICKS = 20,
  parameter int unsigned FIFO_DEPTH     = 4
`ifdef KEYSCAN_AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_TICKS   = 200
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_valid,
  output logic [3:0] key_code,
  input  logic       key_ready,
  output logic       overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [7:0]  DB_LIMIT  = 8'(DEBOUNCE_TICKS);
`ifdef KEYSCAN_AUTOREPEAT_EN
  localparam logic [15:0] REP_LIMIT = 16'(REPEAT_TICKS);
`endif

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    DEBOUNCE,
    PUSH,
    HOLD
  } state_t;

  // ---------------------------------------------------------------------
  // Row synchronizer and scan prescaler
  // ---------------------------------------------------------------------
  logic [3:0]  row_m;
  logic [3:0]  row_s;
  logic [15:0] presc;
  logic        tick;

  // Two-flop synchronizer for the asynchronous row lines (idle level is high).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_m <= '1;
      row_s <= '1;
    end else begin
      row_m <= row;
      row_s <= row_m;
    end
  end

  // Prescaler producing one scan tick every CLK_DIV clocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (presc == DIV_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  assign tick = (presc == DIV_LAST);

  // ---------------------------------------------------------------------
  // Scan / debounce FSM
  // ---------------------------------------------------------------------
  state_t     state, state_d;
  logic [1:0] idx, idx_d;
  logic [1:0] idx_inc;
  logic [3:0] col_q, col_d;
  logic [3:0] cap_row, cap_row_d;
  logic [1:0] cap_col, cap_col_d;
  logic [7:0] db_cnt, db_cnt_d, db_next;
  logic [7:0] rel_cnt, rel_cnt_d, rel_next;
  logic       push;
  logic [3:0] push_code;
`ifdef KEYSCAN_AUTOREPEAT_EN
  logic [15:0] rep_cnt, rep_cnt_d, rep_next;
`endif

  // Lowest-indexed low row wins when several rows are pressed together.
  function automatic logic [1:0] low_row(input logic [3:0] r);
    logic [1:0] res;
    res = 2'd0;
    if (!r[0])      res = 2'd0;
    else if (!r[1]) res = 2'd1;
    else if (!r[2]) res = 2'd2;
    else if (!r[3]) res = 2'd3;
    return res;
  endfunction

  assign push_code = {cap_col, low_row(cap_row)};
  assign idx_inc   = idx + 2'd1;
  assign db_next   = db_cnt + 8'd1;
  assign rel_next  = rel_cnt + 8'd1;
`ifdef KEYSCAN_AUTOREPEAT_EN
  assign rep_next  = rep_cnt + 16'd1;
`endif

  // FSM state and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      col_q   <= '0;
      cap_row <= '1;
      cap_col <= '0;
      db_cnt  <= '0;
      rel_cnt <= '0;
`ifdef KEYSCAN_AUTOREPEAT_EN
      rep_cnt <= '0;
`endif
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      col_q   <= col_d;
      cap_row <= cap_row_d;
      cap_col <= cap_col_d;
      db_cnt  <= db_cnt_d;
      rel_cnt <= rel_cnt_d;
`ifdef KEYSCAN_AUTOREPEAT_EN
      rep_cnt <= rep_cnt_d;
`endif
    end
  end

  // Next-state logic; every transition except PUSH is gated by the scan tick.
  always_comb begin
    state_d   = state;
    idx_d     = idx;
    col_d     = col_q;
    cap_row_d = cap_row;
    cap_col_d = cap_col;
    db_cnt_d  = db_cnt;
    rel_cnt_d = rel_cnt;
    push      = 1'b0;
`ifdef KEYSCAN_AUTOREPEAT_EN
    rep_cnt_d = rep_cnt;
`endif
    case (state)
      IDLE: begin
        col_d = '0;
        if (tick && row_s != 4'b1111) begin
          state_d = SCAN;
          idx_d   = 2'd0;
          col_d   = 4'b1110;
        end
      end
      SCAN: begin
        if (tick) begin
          if (row_s != 4'b1111) begin
            cap_row_d = row_s;
            cap_col_d = idx;
            db_cnt_d  = '0;
            state_d   = DEBOUNCE;
          end else if (idx == 2'd3) begin
            state_d = IDLE;
            col_d   = '0;
          end else begin
            idx_d = idx_inc;
            col_d = ~(4'b0001 << idx_inc);
          end
        end
      end
      DEBOUNCE: begin
        if (tick) begin
          if (row_s == cap_row) begin
            db_cnt_d = db_next;
            if (db_next == DB_LIMIT) begin
              state_d = PUSH;
            end
          end else begin
            state_d = IDLE;
            col_d   = '0;
          end
        end
      end
      PUSH: begin
        push      = 1'b1;
        rel_cnt_d = '0;
        state_d   = HOLD;
`ifdef KEYSCAN_AUTOREPEAT_EN
        rep_cnt_d = '0;
`endif
      end
      HOLD: begin
        if (tick) begin
          if (row_s == 4'b1111) begin
            rel_cnt_d = rel_next;
            if (rel_next == DB_LIMIT) begin
              state_d = IDLE;
              col_d   = '0;
            end
          end else begin
            rel_cnt_d = '0;
          end
        end
`ifdef KEYSCAN_AUTOREPEAT_EN
        // Repeat counter is cleared on any cycle the rows differ from the
        // captured pattern, not only on ticks, so short glitches reset it.
        if (row_s != cap_row) begin
          rep_cnt_d = '0;
        end else if (tick) begin
          if (rep_next == REP_LIMIT) begin
            push      = 1'b1;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_next;
          end
        end
`endif
      end
      default: begin
        state_d = IDLE;
        col_d   = '0;
      end
    endcase
  end

  assign col = col_q;

  // ---------------------------------------------------------------------
  // Key event FIFO
  // ---------------------------------------------------------------------
  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, do_push;

  assign full    = (count == FULL_CNT);
  assign pop     = key_valid & key_ready;
  assign do_push = push & (~full | pop);

  // FIFO storage, pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_code;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign key_valid = (count != '0);
  assign key_code  = mem[rd_ptr];

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a behavioural 4x4 keypad matrix
// and a scoreboard queue of expected key codes.
module tb_keypad_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready;
  logic        overflow;
  logic [15:0] pressed;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [3:0]  sb[$];

  always #5 clk = ~clk;

  keypad_scan_ctrl #(
    .CLK_DIV(4),
    .DEBOUNCE_TICKS(3),
    .FIFO_DEPTH(4)
`ifdef KEYSCAN_AUTOREPEAT_EN
    ,
    .REPEAT_TICKS(10)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .row(row),
    .col(col),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_ready(key_ready),
    .overflow(overflow)
  );

  // Keypad matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!col[c] && pressed[c*4+r]) row[r] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int c, input int r, input int hold);
    pressed[c*4+r] = 1'b1;
    cyc(hold);
    pressed[c*4+r] = 1'b0;
    cyc(60);
  endtask

  // Wait (bounded) for an event, compare against the scoreboard, then pop it.
  task automatic expect_pop(input string tag);
    int waited;
    logic [3:0] exp;
    waited = 0;
    while (!key_valid && waited < 400) begin
      cyc(1);
      waited++;
    end
    if (!key_valid) begin
      check({tag, "_timeout"}, 8'(key_valid), 8'd1);
    end else if (sb.size() == 0) begin
      check({tag, "_unexpected"}, 8'(key_valid), 8'd0);
    end else begin
      exp = sb.pop_front();
      check(tag, 8'(key_code), 8'(exp));
      key_ready = 1'b1;
      cyc(1);
      key_ready = 1'b0;
    end
  endtask

  // With key_ready held high, every sampled key_valid is one popped event.
  task automatic drain_window(input int n, inout int seen);
    logic [3:0] exp;
    for (int i = 0; i < n; i++) begin
      cyc(1);
      if (key_valid) begin
        seen++;
        if (sb.size() == 0) begin
          check("rep_unexpected", 8'(key_valid), 8'd0);
        end else begin
          exp = sb.pop_front();
          check("rep_code", 8'(key_code), 8'(exp));
        end
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int rep_expected;
    pressed   = '0;
    key_ready = 1'b0;
    reset     = 1'b1;
    cyc(3);
    check("rst_col", 8'(col), 8'h0);
    check("rst_valid", 8'(key_valid), 8'h0);
    check("rst_code", 8'(key_code), 8'h0);
    check("rst_ovf", 8'(overflow), 8'h0);
    reset = 1'b0;
    cyc(5);

    // Reset asserted while key 0 is being debounced.
    pressed[0] = 1'b1;
    cyc(13);
    reset = 1'b1;
    #1;
    check("mr_col", 8'(col), 8'h0);
    check("mr_valid", 8'(key_valid), 8'h0);
    check("mr_ovf", 8'(overflow), 8'h0);
    pressed[0] = 1'b0;
    cyc(4);
    reset = 1'b0;
    cyc(80);
    check("mr_noevent", 8'(key_valid), 8'h0);

    // Column 2 / row 1 -> code 9, popped, queue empties.
    sb.push_back(4'd9);
    pressed[2*4+1] = 1'b1;
    expect_pop("k9");
    check("k9_empty", 8'(key_valid), 8'h0);
    pressed = '0;
    cyc(60);

    // Two-tick glitch on column 0 / row 0 -> no event, back to idle.
    pressed[0] = 1'b1;
    cyc(8);
    pressed[0] = 1'b0;
    cyc(60);
    check("gl_valid", 8'(key_valid), 8'h0);
    check("gl_col", 8'(col), 8'h0);

    // Five presses with no consumer: the fifth (code 3) is dropped.
    press(0, 0, 48); sb.push_back(4'd0);
    press(1, 1, 48); sb.push_back(4'd5);
    press(2, 2, 48); sb.push_back(4'd10);
    press(3, 3, 48); sb.push_back(4'd15);
    check("full_ovf", 8'(overflow), 8'h0);
    check("full_valid", 8'(key_valid), 8'h1);
    check("full_head", 8'(key_code), 8'h0);
    press(0, 3, 48);
    check("ovf_set", 8'(overflow), 8'h1);
    expect_pop("drain0");
    expect_pop("drain1");
    expect_pop("drain2");
    expect_pop("drain3");
    check("drain_empty", 8'(key_valid), 8'h0);
    check("ovf_sticky", 8'(overflow), 8'h1);

    // Rows 1 and 3 together in column 1 -> lowest row wins, code 5.
    sb.push_back(4'd5);
    pressed[1*4+1] = 1'b1;
    pressed[1*4+3] = 1'b1;
    expect_pop("multi");
    pressed = '0;
    cyc(60);
    check("multi_empty", 8'(key_valid), 8'h0);

    // Key 7 held for 35 ticks after acceptance.
`ifdef KEYSCAN_AUTOREPEAT_EN
    rep_expected = 4;
`else
    rep_expected = 1;
`endif
    for (int i = 0; i < rep_expected; i++) sb.push_back(4'd7);
    pressed[1*4+3] = 1'b1;
    expect_pop("rep_first");
    seen = 1;
    key_ready = 1'b1;
    drain_window(140, seen);
    pressed = '0;
    drain_window(60, seen);
    key_ready = 1'b0;
    check("rep_count", 8'(seen), 8'(rep_expected));
    check("rep_empty", 8'(key_valid), 8'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
